serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial unsigned subtractor controller that computes `diff = a - b` over WIDTH cycles, LSB first. Each cycle uses one 1-bit full-subtractor cell built from two half-subtractor stages plus an OR for the borrow. The block owns operand/result shift registers, the borrow flip-flop, the bit counter and the start/done handshake. It is the area-minimal subtract path for wide operands where latency is not critical.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when the block is in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the cycle start is accepted.
- b  input  WIDTH  subtrahend; captured on the cycle start is accepted.
- busy  output  1  high in RUN and DONE states.
- done  output  1  single-cycle pulse: result valid.
- diff  output  WIDTH  result `(a - b) mod 2^WIDTH`; held from done until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned); held with diff.

## Operation
- States:
  - IDLE: reset state.
  - RUN: WIDTH bit-steps.
  - DONE: one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE when the bit counter reaches WIDTH-1 on a step.
  - DONE→RUN if start is high; otherwise DONE→IDLE.
- Start acceptance, in IDLE or DONE:
  - Load sa←a and sb←b.
  - Clear the borrow flip-flop to 0 and the counter to 0.
  - Clear the result shift register to 0.
- Bit-step, each RUN cycle, on x=sa[0], y=sb[0], bin=borrow flip-flop:
  - Stage 1: d1 = x^y; b1 = ~x&y.
  - Stage 2: d = d1^bin; b2 = ~d1&bin.
  - bout = b1|b2.
  - Register updates: result ← {d, result[WIDTH-1:1]}; sa, sb shift right (zero fill); borrow ← bout; counter += 1.
- On entry to DONE:
  - diff ← final result, after the last shift.
  - borrow_out ← final bout.
  - done = 1.
- start is ignored in RUN: no restart, no operand recapture.
- Counter width is clog2(WIDTH)+1. For WIDTH=1, RUN lasts exactly one cycle.
- Operand inputs a/b are don't-care except on the accept cycle.

## Timing
- Reset, asynchronous, any state including mid-RUN:
  - State is IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - sa, sb, result, counter and borrow are all 0.
  - An in-flight operation is discarded; there is no done pulse for it.
- Latency: start accepted at rising edge k. RUN covers edges k+1..k+WIDTH. done=1 in the cycle after edge k+WIDTH.
- busy goes high after edge k and is low only in IDLE.
- done is high exactly one cycle per accepted start and is registered (no combinational path from start).
- diff and borrow_out change only on the edge entering DONE and are stable otherwise, including while a new operation runs.
- Back-to-back: start high during DONE is accepted. The next done comes WIDTH+1 cycles after the previous done (maximum throughput).
- start held high continuously gives one operation per WIDTH+1 cycles, with no extra accepts during RUN.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, one-cycle start:
  - busy rises next cycle.
  - done pulses exactly 9 cycles after the accept edge.
  - diff=0x1E, borrow_out=0.
- WIDTH=8, a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Then a=0xAA, b=0xAA → diff=0x00, borrow_out=0.
- Start re-pulsed mid-RUN with a=0xFF, b=0x00 on an op of a=0x10, b=0x20:
  - The second start is ignored.
  - diff=0xF0, borrow_out=1, done once.
  - diff is held until the next accepted start.
- rst_n asserted asynchronously (mid-cycle) 4 cycles into an op:
  - All outputs read 0 immediately.
  - No done pulse follows.
  - A fresh start after release gives correct results at nominal latency.
- Back-to-back: start held high for 20 cycles with constant a=0x80, b=0x7F:
  - done pulses at 9-cycle spacing.
  - diff=0x01, borrow_out=0 each time.
- Random sweep, WIDTH=1, 8 and 13, ≥1000 ops each: diff/borrow_out match the `{borrow, diff} = {1'b0,a} - {1'b0,b}` model. For WIDTH=1, done arrives 2 cycles after accept.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per cycle, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one op per WIDTH+1 cycles.
// Backpressure: start is sampled only in IDLE/DONE; requests during RUN are dropped.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [CW-1:0]   cnt_q;
    logic            bor_q, busy_q, done_q, bo_q;

    logic [WIDTH-1:0] sa_d, sb_d, res_d;
    logic             d1, b1, d, b2, bout, last;

    // Full-subtractor cell (two half-subtractors + OR) and the shifted register values.
    always_comb begin
        d1    = sa_q[0] ^ sb_q[0];
        b1    = ~sa_q[0] & sb_q[0];
        d     = d1 ^ bor_q;
        b2    = ~d1 & bor_q;
        bout  = b1 | b2;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_q >> 1;
        res_d[WIDTH-1] = d;
        last  = (cnt_q == CNT_LAST);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        sa_q    <= a;
                        sb_q    <= b;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        bor_q   <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    res_q <= res_d;
                    bor_q <= bout;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last) begin
                        // Result is published only here so it stays stable across later runs.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bo_q    <= bout;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [12:0] a_v, b_v;
    int          sel_mon;
    int          checks = 0;
    int          errors = 0;

    logic        busy1, done1, diff1, bo1;
    logic        busy8, done8, bo8;
    logic [7:0]  diff8;
    logic        busy13, done13, bo13;
    logic [12:0] diff13;

    logic        busy_m, done_m, bo_m;
    logic [12:0] diff_m;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0:0]), .b(b_v[0:0]),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

    serial_sub_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[7:0]), .b(b_v[7:0]),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));

    serial_sub_ctrl #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v), .b(b_v),
        .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13));

    // Route the instance under test to a common set of monitor signals.
    always_comb begin
        busy_m = 1'b0;
        done_m = 1'b0;
        diff_m = '0;
        bo_m   = 1'b0;
        case (sel_mon)
            0: begin busy_m = busy1;  done_m = done1;  diff_m = {12'b0, diff1}; bo_m = bo1;  end
            1: begin busy_m = busy8;  done_m = done8;  diff_m = {5'b0, diff8};  bo_m = bo8;  end
            2: begin busy_m = busy13; done_m = done13; diff_m = diff13;         bo_m = bo13; end
            default: ;
        endcase
    end

    function automatic int width_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 8 : 13;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step negedges until done is seen or the budget runs out; n counts negedges since start was driven.
    task automatic wait_done(input int limit, inout int n);
        while (!done_m && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One complete operation; called just after a negedge, returns just after the negedge following done.
    task automatic run_op(input int sel, input logic [12:0] a, input logic [12:0] b, input string tag);
        int          w;
        int          n;
        logic [13:0] mask, am, bm, ed;
        w    = width_of(sel);
        mask = (14'd1 << w) - 14'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        ed   = (am - bm) & mask;
        sel_mon = sel;
        a_v = a;
        b_v = b;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        n = 1;
        check({tag, "_busy"}, {31'b0, busy_m}, 32'd1);
        wait_done(w + 4, n);
        check({tag, "_lat"}, n, w + 1);
        check({tag, "_diff"}, {19'b0, diff_m}, {18'b0, ed});
        check({tag, "_bo"}, {31'b0, bo_m}, {31'b0, (am < bm)});
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done_m}, 32'd0);
    endtask

    initial begin
        int n;
        int ndone;
        int last_n;
        rst_n   = 1'b0;
        start_v = '0;
        a_v     = '0;
        b_v     = '0;
        sel_mon = 1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy_m}, 32'd0);
        check("rst_done", {31'b0, done_m}, 32'd0);
        check("rst_diff", {19'b0, diff_m}, 32'd0);
        check("rst_bo",   {31'b0, bo_m},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'b0, busy_m}, 32'd0);

        // Directed operations at WIDTH=8.
        run_op(1, 13'h5A, 13'h3C, "d5a3c");
        run_op(1, 13'h00, 13'h01, "d0001");
        run_op(1, 13'hAA, 13'hAA, "daaaa");

        // Restart attempt mid-RUN must be ignored.
        sel_mon = 1;
        a_v = 13'h10; b_v = 13'h20; start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0; n = 1;
        @(negedge clk); n++;
        @(negedge clk); n++;
        a_v = 13'hFF; b_v = 13'h00; start_v[1] = 1'b1;
        @(negedge clk); n++; start_v[1] = 1'b0;
        check("mid_busy", {31'b0, busy_m}, 32'd1);
        wait_done(12, n);
        check("mid_lat",  n, 9);
        check("mid_diff", {19'b0, diff_m}, 32'hF0);
        check("mid_bo",   {31'b0, bo_m}, 32'd1);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_m) ndone++;
        end
        check("mid_once", ndone, 0);
        check("mid_hold", {19'b0, diff_m}, 32'hF0);
        a_v = 13'h33; b_v = 13'h11; start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0; n = 1;
        repeat (3) begin @(negedge clk); n++; end
        check("run_hold_diff", {19'b0, diff_m}, 32'hF0);
        check("run_hold_bo",   {31'b0, bo_m},   32'd1);
        wait_done(12, n);
        check("next_diff", {19'b0, diff_m}, 32'h22);
        @(negedge clk);

        // Asynchronous reset in the middle of a cycle, four cycles into an operation.
        a_v = 13'h5A; b_v = 13'h3C; start_v[1] = 1'b1;
        @(negedge clk); start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy_m}, 32'd0);
        check("arst_done", {31'b0, done_m}, 32'd0);
        check("arst_diff", {19'b0, diff_m}, 32'd0);
        check("arst_bo",   {31'b0, bo_m},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_m) ndone++;
        end
        check("arst_nodone", ndone, 0);
        run_op(1, 13'hC3, 13'h3C, "post_rst");

        // Start held high: one op per WIDTH+1 cycles.
        sel_mon = 1;
        a_v = 13'h80; b_v = 13'h7F; start_v[1] = 1'b1;
        ndone = 0; last_n = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 20) start_v[1] = 1'b0;
            if (done_m) begin
                ndone++;
                check("b2b_gap",  i - last_n, 9);
                check("b2b_diff", {19'b0, diff_m}, 32'h01);
                check("b2b_bo",   {31'b0, bo_m},   32'd0);
                last_n = i;
            end
        end
        check("b2b_count", ndone, 3);

        // Random sweep across widths, with a share of equal and extreme operands.
        for (int sel = 0; sel < 3; sel++) begin
            for (int k = 0; k < 1000; k++) begin
                logic [12:0] ra, rb;
                ra = 13'($urandom);
                rb = 13'($urandom);
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: ra = '0;
                    2: rb = '1;
                    3: begin ra = '1; rb = '0; end
                    default: ;
                endcase
                run_op(sel, ra, rb, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
